gt_cmp_sched: RTL

Round-robin scheduler that time-shares one combinational 4-bit greater-than comparator (`gt_4bit`) among `N_REQ` requesters. Each requester presents an operand pair with a level request. The block grants one requester at a time, drives the shared comparator's operands, captures its `agtb` result and returns it with a one-cycle acknowledge. It sits between client logic and the single comparator instance, so the comparator is instantiated once, outside this block.

---
 rtl/gt_cmp_sched_if.sv | 29 ++
 rtl/gt_cmp_sched.sv | 118 +++++++++++
 2 files changed

// File: rtl/gt_cmp_sched_if.sv
// Bundle of signals between the requesters, the shared comparator and the
// scheduler. The master side is the environment: it holds the client request
// ports and the externally instantiated gt_4bit. The slave side is the scheduler.
interface gt_cmp_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = 2
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] a_in;
    logic [N_REQ*W-1:0] b_in;
    logic [W-1:0]       cmp_a;
    logic [W-1:0]       cmp_b;
    logic               cmp_agtb;
    logic [N_REQ-1:0]   ack;
    logic               agtb_out;
    logic [IDW-1:0]     gnt_id;
    logic               busy;

    modport master (
        output req, a_in, b_in, cmp_agtb,
        input  cmp_a, cmp_b, ack, agtb_out, gnt_id, busy
    );

    modport slave (
        input  req, a_in, b_in, cmp_agtb,
        output cmp_a, cmp_b, ack, agtb_out, gnt_id, busy
    );
endinterface

// File: rtl/gt_cmp_sched.sv
// Round-robin scheduler that time-shares one external combinational
// greater-than comparator among N_REQ requesters. Each transaction takes
// IDLE -> LOAD -> DONE: operands are registered onto the comparator in LOAD,
// the result is captured at the end of LOAD and acknowledged during DONE.
module gt_cmp_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int IDW   = 2
) (
    input  logic              clk,
    input  logic              rst,
    gt_cmp_sched_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gnt_q, gnt_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               agtb_q, agtb_d;
    logic [N_REQ-1:0]   ack_q, ack_d;

    logic               found;
    logic [IDW-1:0]     sel;
    logic [IDW-1:0]     sel_inc;

    // Round-robin search: first set request starting at ptr, wrapping at N_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                sel   = IDW'(idx);
            end
        end
        // Explicit wrap so a non-power-of-two N_REQ never yields the value N_REQ.
        if (int'(sel) == N_REQ - 1) begin
            sel_inc = '0;
        end else begin
            sel_inc = sel + IDW'(1);
        end
    end

    // Next-state and datapath-register update decisions for the FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        a_d     = a_q;
        b_d     = b_q;
        agtb_d  = agtb_q;
        ack_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = bus.a_in[int'(sel)*W +: W];
                    b_d     = bus.b_in[int'(sel)*W +: W];
                    gnt_d   = sel;
                    ptr_d   = sel_inc;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                agtb_d       = bus.cmp_agtb;
                ack_d[gnt_q] = 1'b1;
                state_d      = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            agtb_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            agtb_q  <= agtb_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.cmp_a    = a_q;
    assign bus.cmp_b    = b_q;
    assign bus.gnt_id   = gnt_q;
    assign bus.agtb_out = agtb_q;
    assign bus.ack      = ack_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
